dem_bcd_updown: RTL and testbench

DEM_BCD_UPDOWN -- requirements
Module: dem_bcd_updown

---
 rtl/dem_bcd_updown.sv | 121 ++++++++++++
 tb/tb_dem_bcd_updown.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dem_bcd_updown.sv
// Cascaded BCD up/down counter stepped by a 32-bit prescaler.
// It can wrap or stop at the terminal count and supports a synchronous clamped load.

module dem_bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] nd,
  output logic       cout
);
  always_comb begin
    nd   = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          nd   = 4'd0;
          cout = 1'b1;
        end else begin
          nd = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nd   = 4'd9;
          cout = 1'b1;
        end else begin
          nd = d - 4'd1;
        end
      end
    end
  end
endmodule

module dem_bcd_updown #(
  parameter int          DIGITS = 2,
  parameter int unsigned DIV    = 50000000,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic                  tc,
  output logic                  done
);
  typedef enum logic {RUN, STOP} state_t;

  localparam logic [31:0] PRESC_MAX = 32'(DIV - 1);

  state_t                state, state_nx;
  logic [31:0]           presc;
  logic [DIGITS:0]       carry;
  logic [4*DIGITS-1:0]   q_nx, din_c;
  logic [DIGITS-1:0]     dig_term;
  logic                  step, term, unused_carry;

  // Digit 0 always receives the unit increment/decrement; the rest ripple.
  assign carry[0]     = 1'b1;
  assign unused_carry = carry[DIGITS];

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      dem_bcd_digit u_dig (
        .d    (q[4*g +: 4]),
        .up   (up),
        .cin  (carry[g]),
        .nd   (q_nx[4*g +: 4]),
        .cout (carry[g+1])
      );
      assign din_c[4*g +: 4] = (din[4*g +: 4] > 4'd9) ? 4'd9 : din[4*g +: 4];
      assign dig_term[g]     = up ? (q_nx[4*g +: 4] == 4'd9) : (q_nx[4*g +: 4] == 4'd0);
    end
  endgenerate

  assign term = &dig_term;
  assign step = enable && (state == RUN) && (presc == PRESC_MAX);
  assign done = (state == STOP);

  always_comb begin
    state_nx = state;
    if (load)
      state_nx = RUN;
    else if (step && term && (WRAP == 1'b0))
      state_nx = STOP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      presc <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      q     <= din_c;
      presc <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      tick <= step;
      tc   <= step && term;
      if (step) begin
        q     <= q_nx;
        presc <= '0;
      end else if (state == STOP) begin
        presc <= '0;
      end else if (enable) begin
        presc <= presc + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_dem_bcd_updown.sv
// Bench for dem_bcd_updown: a wrapping DIV=4 instance and a stopping DIV=1 instance share
// their inputs, and both are compared each cycle against an integer-arithmetic model.

module tb_dem_bcd_updown;
  logic       clk = 1'b0, reset = 1'b0, enable = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] q_w, q_s;
  logic       tick_w, tc_w, done_w, tick_s, tc_s, done_s;

  always #5 clk = ~clk;

  dem_bcd_updown #(.DIGITS(2), .DIV(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load), .din(din),
    .q(q_w), .tick(tick_w), .tc(tc_w), .done(done_w));

  dem_bcd_updown #(.DIGITS(2), .DIV(1), .WRAP(1'b0)) u_stop (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load), .din(din),
    .q(q_s), .tick(tick_s), .tc(tc_s), .done(done_s));

  int n_chk = 0, n_pass = 0;

  // Model state per instance: 0 = u_wrap, 1 = u_stop.
  int m_val[2], m_pre[2];
  bit m_stop[2], m_tick[2], m_tc[2];
  int m_div[2]  = '{4, 1};
  bit m_wrap[2] = '{1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    int hi, lo;
    hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_pre[k] = 0; m_stop[k] = 1'b0; m_tick[k] = 1'b0; m_tc[k] = 1'b0;
    end
  endtask

  task automatic model_clk();
    int nv, tv;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      m_tick[k] = 1'b0;
      m_tc[k]   = 1'b0;
      if (load) begin
        m_val[k] = bcd2int(din); m_pre[k] = 0; m_stop[k] = 1'b0;
      end else if (!m_stop[k] && enable && m_pre[k] == m_div[k] - 1) begin
        nv = up ? (m_val[k] + 1) % 100 : (m_val[k] + 99) % 100;
        tv = up ? 99 : 0;
        m_pre[k]  = 0;
        m_tick[k] = 1'b1;
        m_tc[k]   = (nv == tv);
        if (!m_wrap[k] && nv == tv) m_stop[k] = 1'b1;
        m_val[k] = nv;
      end else if (m_stop[k]) begin
        m_pre[k] = 0;
      end else if (enable) begin
        m_pre[k]++;
      end
    end
  endtask

  task automatic check_all();
    chk("wrap.q",    q_w,    int2bcd(m_val[0]));
    chk("wrap.tick", tick_w, m_tick[0]);
    chk("wrap.tc",   tc_w,   m_tc[0]);
    chk("wrap.done", done_w, m_stop[0]);
    chk("stop.q",    q_s,    int2bcd(m_val[1]));
    chk("stop.tick", tick_s, m_tick[1]);
    chk("stop.tc",   tc_s,   m_tc[1]);
    chk("stop.done", done_s, m_stop[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    cycle();
    reset = 1'b1; enable = 1'b1; up = 1'b1;

    // Up with carry: 08 -> 09 -> 10 at 4-cycle spacing
    load = 1'b1; din = 8'h08; cycle(); load = 1'b0;
    repeat (8) cycle();
    chk("c_carry.q",    q_w,    8'h10);
    chk("c_carry.tick", tick_w, 1'b1);
    chk("c_carry.tc",   tc_w,   1'b0);
    repeat (4) cycle();

    // Up wrap: 98 -> 99 (tc) -> 00 (no tc)
    load = 1'b1; din = 8'h98; cycle(); load = 1'b0;
    repeat (4) cycle();
    chk("c_wrap99.q",  q_w,  8'h99);
    chk("c_wrap99.tc", tc_w, 1'b1);
    repeat (4) cycle();
    chk("c_wrap00.q",  q_w,  8'h00);
    chk("c_wrap00.tc", tc_w, 1'b0);

    // Down stop on the DIV=1, WRAP=0 instance
    up = 1'b0; load = 1'b1; din = 8'h02; cycle(); load = 1'b0;
    cycle();
    chk("c_down01.q", q_s, 8'h01);
    cycle();
    chk("c_down00.q",  q_s,    8'h00);
    chk("c_down.tc",   tc_s,   1'b1);
    chk("c_down.done", done_s, 1'b1);
    repeat (12) cycle();
    chk("c_hold.q",    q_s,    8'h00);
    chk("c_hold.done", done_s, 1'b1);
    up = 1'b1; cycle();
    chk("c_uptoggle.done", done_s, 1'b1);
    load = 1'b1; din = 8'h05; cycle(); load = 1'b0;
    chk("c_reload.done", done_s, 1'b0);
    chk("c_reload.q",    q_s,    8'h05);
    up = 1'b0; cycle();
    chk("c_resume.q", q_s, 8'h04);

    // Load coincident with a step, with clamp of the upper digit
    load = 1'b1; din = 8'h08; cycle(); load = 1'b0;
    repeat (3) cycle();
    load = 1'b1; din = 8'hA3; cycle(); load = 1'b0;
    chk("c_clamp.q",    q_w,    8'h93);
    chk("c_clamp.tick", tick_w, 1'b0);
    repeat (3) cycle();
    chk("c_restart.tick0", tick_w, 1'b0);
    cycle();
    chk("c_restart.tick1", tick_w, 1'b1);

    // Hold mid-period, then a direction change mid-period
    up = 1'b1; load = 1'b1; din = 8'h40; cycle(); load = 1'b0;
    repeat (2) cycle();
    enable = 1'b0;
    repeat (7) cycle();
    chk("c_freeze.q", q_w, 8'h40);
    enable = 1'b1;
    cycle();
    chk("c_remain.tick", tick_w, 1'b0);
    cycle();
    chk("c_remain.q", q_w, 8'h41);
    cycle();
    up = 1'b0;
    repeat (3) cycle();
    chk("c_dirchg.q", q_w, 8'h40);

    // Async reset mid-count, between edges
    enable = 1'b0; load = 1'b1; din = 8'h57; cycle(); load = 1'b0;
    cycle();
    chk("c_pre_rst.q", q_w, 8'h57);
    #2 reset = 1'b0;
    #1;
    chk("c_arst.q_w",    q_w,    8'h00);
    chk("c_arst.q_s",    q_s,    8'h00);
    chk("c_arst.done_s", done_s, 1'b0);
    model_reset();
    cycle();
    reset = 1'b1;

    // Async reset while stopped
    enable = 1'b1; up = 1'b0; load = 1'b1; din = 8'h01; cycle(); load = 1'b0;
    cycle();
    chk("c_stopped.done", done_s, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("c_arst_stop.done", done_s, 1'b0);
    chk("c_arst_stop.q",    q_s,    8'h00);
    model_reset();
    cycle();
    reset = 1'b1; up = 1'b1;

    // First step DIV enabled cycles after deassertion
    repeat (3) cycle();
    chk("c_first.tick0", tick_w, 1'b0);
    cycle();
    chk("c_first.tick1", tick_w, 1'b1);

    repeat (1500) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      load = ($urandom_range(0, 24) == 0);
      din  = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
